// File: rtl/cds_pkg.sv
// Shared definitions for the CDS sample subtractor.
// State encoding, derived widths and counter width.
package cds_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HAVE_S1 = 2'd1,
    HAVE_S2 = 2'd2
  } cds_state_e;

  localparam int FRAME_CNT_W = 16;

  function automatic int cds_diff_w(input int adc_w);
    return adc_w + 1;
  endfunction

endpackage

// File: rtl/cds_out_fifo.sv
// Two-entry output FIFO for CDS results.
// A pop in the same cycle frees a slot for a push on full.
module cds_out_fifo #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_data
);

  logic [W-1:0] r_mem [2];
  logic         r_wr;
  logic         r_rd;
  logic [1:0]   r_cnt;
  logic         w_wr;

  assign o_full  = (r_cnt == 2'd2);
  assign o_empty = (r_cnt == 2'd0);
  assign o_data  = r_mem[r_rd];
  assign w_wr    = i_push & (~o_full | i_pop);

  // Storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wr  <= 1'b0;
      r_rd  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= ~r_wr;
      end
      if (i_pop) r_rd <= ~r_rd;
      r_cnt <= r_cnt + {1'b0, w_wr} - {1'b0, i_pop};
    end
  end

endmodule

// File: rtl/cds_sample_subtractor.sv
// Digital CDS: captures reset/signal samples, streams s1-s2.
// Define CDS_AVG_EN to average 2^AVG_LOG2 reads per result.
module cds_sample_subtractor
  import cds_pkg::*;
#(
  parameter int ADC_W    = 12,
  parameter int ADC_LAT  = 2,
  parameter int AVG_LOG2 = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cds_clk1,
  input  logic                   cds_clk2,
  input  logic                   cds_done,
  input  logic [ADC_W-1:0]       adc_data,
  output logic [ADC_W:0]         out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   seq_err,
  output logic                   overrun,
  input  logic                   err_clr
);

  localparam int DIFF_W = cds_diff_w(ADC_W);
  localparam logic [2:0] LAT3 = 3'(ADC_LAT);

  logic r_clk1_q, r_clk2_q, r_done_q;
  logic w_e1, w_e2, w_ed;
  cds_state_e r_state, w_nxt;
  logic w_cap1, w_cap2, w_err, w_done;
  logic w_c1, w_c2;
  logic [ADC_W-1:0] r_s1, r_s2, w_s2;
  logic [2:0] r_s2_cnt;
  logic [7:0] r_ppv;
  logic w_push_now, w_defer, w_push_raw, w_push;
  logic [DIFF_W-1:0] w_diff, w_pdata;
  logic w_full, w_empty, w_pop, w_drop;

  // Previous strobe levels for rising-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk1_q <= 1'b0;
      r_clk2_q <= 1'b0;
      r_done_q <= 1'b0;
    end else begin
      r_clk1_q <= cds_clk1;
      r_clk2_q <= cds_clk2;
      r_done_q <= cds_done;
    end
  end

  assign w_e1 = cds_clk1 & ~r_clk1_q;
  assign w_e2 = cds_clk2 & ~r_clk2_q;
  assign w_ed = cds_done & ~r_done_q;

  // Read-sequence state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nxt;
  end

  // Strobe-order decoding: captures, completion and errors
  always_comb begin
    w_nxt  = r_state;
    w_cap1 = 1'b0;
    w_cap2 = 1'b0;
    w_err  = 1'b0;
    w_done = 1'b0;
    if (w_e1 & w_e2) begin
      w_err = 1'b1;
      w_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_e2 | w_ed) w_err = 1'b1;
          if (w_e1) begin
            w_cap1 = 1'b1;
            w_nxt  = HAVE_S1;
          end
        end
        HAVE_S1: begin
          if (w_e1) begin
            w_err  = 1'b1;
            w_cap1 = 1'b1;
          end else if (w_ed) begin
            w_err = 1'b1;
            w_nxt = IDLE;
          end else if (w_e2) begin
            w_cap2 = 1'b1;
            w_nxt  = HAVE_S2;
          end
        end
        HAVE_S2: begin
          if (w_ed) begin
            w_done = 1'b1;
            w_nxt  = IDLE;
            if (w_e1) begin
              w_cap1 = 1'b1;
              w_nxt  = HAVE_S1;
            end
          end else if (w_e1) begin
            w_err  = 1'b1;
            w_cap1 = 1'b1;
            w_nxt  = HAVE_S1;
          end else if (w_e2) begin
            w_err  = 1'b1;
            w_cap2 = 1'b1;
          end
        end
        default: w_nxt = IDLE;
      endcase
    end
  end

  generate
    if (ADC_LAT == 0) begin : g_lat0
      assign w_c1 = w_cap1;
      assign w_c2 = w_cap2;
    end else begin : g_lat
      logic [ADC_LAT-1:0] r_p1, r_p2;
      // Pulse delay lines aligning captures with ADC latency
      always_ff @(posedge clk) begin
        if (reset) begin
          r_p1 <= '0;
          r_p2 <= '0;
        end else begin
          r_p1 <= (r_p1 << 1) | ADC_LAT'(w_cap1);
          r_p2 <= (r_p2 << 1) | ADC_LAT'(w_cap2);
        end
      end
      assign w_c1 = r_p1[ADC_LAT-1];
      assign w_c2 = r_p2[ADC_LAT-1];
    end
  endgenerate

  // Sample registers loaded when a delayed capture lands
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      if (w_c1) r_s1 <= adc_data;
      if (w_c2) r_s2 <= adc_data;
    end
  end

  // Cycles until the most recent s2 capture lands
  always_ff @(posedge clk) begin
    if (reset)              r_s2_cnt <= 3'd0;
    else if (w_cap2)        r_s2_cnt <= LAT3;
    else if (r_s2_cnt != 0) r_s2_cnt <= r_s2_cnt - 3'd1;
  end

  assign w_push_now = w_done & (r_s2_cnt <= 3'd1);
  assign w_defer    = w_done & (r_s2_cnt > 3'd1);

  // Deferred pushes timed to the landing cycle of their s2
  always_ff @(posedge clk) begin
    if (reset) r_ppv <= 8'd0;
    else r_ppv <= (r_ppv >> 1) |
                  (w_defer ? (8'd1 << (r_s2_cnt - 3'd2)) : 8'd0);
  end

  assign w_push_raw = w_push_now | r_ppv[0];
  assign w_s2       = w_c2 ? adc_data : r_s2;
  assign w_diff     = {1'b0, r_s1} - {1'b0, w_s2};

`ifdef CDS_AVG_EN
  localparam int ACC_W = DIFF_W + AVG_LOG2;
  localparam int BLK_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  logic signed [ACC_W-1:0] r_acc, w_sum;
  logic [BLK_W-1:0] r_blk;
  logic w_last;

  assign w_sum  = r_acc + ACC_W'($signed(w_diff));
  assign w_last = (r_blk == BLK_W'((1 << AVG_LOG2) - 1));

  // Block accumulator of consecutive differences
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
      r_blk <= '0;
    end else if (w_push_raw) begin
      if (w_last) begin
        r_acc <= '0;
        r_blk <= '0;
      end else begin
        r_acc <= w_sum;
        r_blk <= r_blk + 1'b1;
      end
    end
  end

  assign w_push  = w_push_raw & w_last;
  assign w_pdata = DIFF_W'(w_sum >>> AVG_LOG2);
`else
  assign w_push  = w_push_raw;
  assign w_pdata = w_diff;
`endif

  assign out_valid = ~w_empty;
  assign w_pop     = out_valid & out_ready;
  assign w_drop    = w_push & w_full & ~w_pop;

  cds_out_fifo #(.W(DIFF_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_pdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_data  (out_data)
  );

  // Completed-read counter and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
      seq_err   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (w_done) frame_cnt <= frame_cnt + 1'b1;
      seq_err <= (seq_err & ~err_clr) | w_err;
      overrun <= (overrun & ~err_clr) | w_drop;
    end
  end

endmodule

// File: tb/tb_cds_sample_subtractor.sv
// Bench for cds_sample_subtractor: directed reads plus random
// strobe traffic against a per-read reference model.
module tb_cds_sample_subtractor;

  localparam int ADC_W = 12;
  localparam int LAT   = 2;
  localparam int AVGL  = 2;
  localparam int DW    = ADC_W + 1;
  localparam int NCYC  = 4000;

  logic clk = 1'b0;
  logic reset, cds_clk1, cds_clk2, cds_done;
  logic out_valid, out_ready, seq_err, overrun, err_clr;
  logic [ADC_W-1:0] adc_data;
  logic [DW-1:0] out_data;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  cds_sample_subtractor #(
    .ADC_W(ADC_W), .ADC_LAT(LAT), .AVG_LOG2(AVGL)
  ) dut (
    .clk(clk), .reset(reset),
    .cds_clk1(cds_clk1), .cds_clk2(cds_clk2),
    .cds_done(cds_done), .adc_data(adc_data),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .frame_cnt(frame_cnt),
    .seq_err(seq_err), .overrun(overrun),
    .err_clr(err_clr)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: each read's result is s1 - s2 taken from the
  // ADC words at the capture-landing cycles; it enters the FIFO at
  // the later of the done edge and the s2 landing.
  typedef struct { int cyc; logic [DW-1:0] val; } due_t;

  logic [ADC_W-1:0] adc_arr [NCYC];
  int t = 0;
  due_t due_q[$];
  logic [DW-1:0] m_q[$];
  int m_st = 0;
  int s1_at = 0, s2_at = 0;
  logic [15:0] m_frames = 0;
  logic m_seq = 0, m_ovf = 0;
  logic p1 = 0, p2 = 0, pd = 0;
  int avg_sum = 0, avg_n = 0;

  task automatic deliver(input logic [DW-1:0] v, inout logic ovf);
    if (m_q.size() < 2) m_q.push_back(v);
    else ovf = 1'b1;
  endtask

  task automatic model(input logic c1, c2, cd, rdy, clr, rst);
    logic e1, e2, ed, err, ovf;
    logic [DW-1:0] v, junk;
    due_t d;
    if (rst) begin
      m_st = 0; m_q.delete(); due_q.delete();
      m_frames = 0; m_seq = 0; m_ovf = 0;
      p1 = 0; p2 = 0; pd = 0; avg_sum = 0; avg_n = 0;
      return;
    end
    e1 = c1 & ~p1; e2 = c2 & ~p2; ed = cd & ~pd;
    p1 = c1; p2 = c2; pd = cd;
    err = 0; ovf = 0;
    if (e1 && e2) begin
      err = 1; m_st = 0;
    end else if (m_st == 0) begin
      if (e2 || ed) err = 1;
      if (e1) begin s1_at = t + LAT; m_st = 1; end
    end else if (m_st == 1) begin
      if (e1) begin err = 1; s1_at = t + LAT; end
      else if (ed) begin err = 1; m_st = 0; end
      else if (e2) begin s2_at = t + LAT; m_st = 2; end
    end else begin
      if (ed) begin
        d.val = {1'b0, adc_arr[s1_at]} - {1'b0, adc_arr[s2_at]};
        d.cyc = (s2_at > t) ? s2_at : t;
        due_q.push_back(d);
        m_frames++;
        m_st = 0;
        if (e1) begin s1_at = t + LAT; m_st = 1; end
      end else if (e1) begin
        err = 1; s1_at = t + LAT; m_st = 1;
      end else if (e2) begin
        err = 1; s2_at = t + LAT;
      end
    end
    if (m_q.size() > 0 && rdy) junk = m_q.pop_front();
    while (due_q.size() > 0 && due_q[0].cyc <= t) begin
      d = due_q.pop_front();
`ifdef CDS_AVG_EN
      avg_sum += int'($signed(d.val));
      avg_n++;
      if (avg_n == (1 << AVGL)) begin
        v = DW'(avg_sum >>> AVGL);
        avg_sum = 0; avg_n = 0;
        deliver(v, ovf);
      end
`else
      deliver(d.val, ovf);
`endif
    end
    m_seq = clr ? err : (m_seq | err);
    m_ovf = clr ? ovf : (m_ovf | ovf);
  endtask

  task automatic step(input logic c1, c2, cd, rdy, clr, rst);
    cds_clk1 = c1; cds_clk2 = c2; cds_done = cd;
    out_ready = rdy; err_clr = clr; reset = rst;
    adc_data = adc_arr[t];
    @(negedge clk);
    chk("valid", out_valid, m_q.size() > 0);
    if (m_q.size() > 0) chk("data", out_data, m_q[0]);
    chk("frame_cnt", frame_cnt, m_frames);
    chk("seq_err", seq_err, m_seq);
    chk("overrun", overrun, m_ovf);
    model(c1, c2, cd, rdy, clr, rst);
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic idle(input logic rdy);
    step(0, 0, 0, rdy, 0, 0);
  endtask

  task automatic rd(input int s1v, input int s2v, input logic rdy);
    adc_arr[t + LAT] = ADC_W'(s1v);
    step(1, 0, 0, rdy, 0, 0);
    idle(rdy);
    adc_arr[t + LAT] = ADC_W'(s2v);
    step(0, 1, 0, rdy, 0, 0);
    idle(rdy);
    idle(rdy);
    step(0, 0, 1, rdy, 0, 0);
  endtask

  initial begin
    logic [DW-1:0] neg;
    logic c1, c2, cd, rdy, clr, rst;
    int ph, gap;
    for (int i = 0; i < NCYC; i++) adc_arr[i] = ADC_W'($urandom_range(4095));
    reset = 1; cds_clk1 = 0; cds_clk2 = 0; cds_done = 0;
    out_ready = 0; err_clr = 0; adc_data = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", out_data, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_frames", frame_cnt, 0);
    chk("rst_seq", seq_err, 0);
    chk("rst_ovf", overrun, 0);
    idle(1);

`ifdef CDS_AVG_EN
    rd(110, 100, 0);
    rd(120, 100, 0);
    rd(130, 100, 0);
    idle(0);
    chk("avg_none_yet", out_valid, 0);
    rd(96, 100, 0);
    chk("avg_valid", out_valid, 1);
    chk("avg_data", out_data, 14);
    chk("avg_frames", frame_cnt, 4);
    idle(1);
`else
    rd(3000, 1000, 0);
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 2000);
    chk("t1_frames", frame_cnt, 1);
    idle(1);
    rd(100, 4000, 0);
    neg = DW'(-3900);
    chk("t2_data", out_data, neg);
    for (int i = 0; i < 5; i++) begin
      idle(0);
      chk("t2_hold", out_data, neg);
    end
    idle(1);
    chk("t2_drained", out_valid, 0);
    rd(500, 100, 0);
    rd(700, 200, 0);
    rd(900, 300, 0);
    chk("t3_ovf", overrun, 1);
    chk("t3_frames", frame_cnt, 5);
    chk("t3_head0", out_data, 400);
    idle(1);
    chk("t3_head1", out_data, 500);
    step(0, 0, 0, 0, 1, 0);
    chk("t3_clr", overrun, 0);
    idle(1);
    chk("t3_empty", out_valid, 0);
    step(0, 1, 0, 1, 0, 0);
    chk("t4_seq", seq_err, 1);
    chk("t4_noout", out_valid, 0);
    step(0, 0, 0, 1, 1, 0);
    step(1, 1, 0, 1, 0, 0);
    chk("t4_both", seq_err, 1);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 0, 0);
    chk("t4_idle", seq_err, 1);
    chk("t4_frames", frame_cnt, 5);
    step(0, 0, 0, 1, 1, 0);
    adc_arr[t + LAT] = 12'd1234;
    step(1, 0, 0, 1, 0, 0);
    idle(1);
    adc_arr[t + LAT] = 12'd34;
    step(0, 1, 0, 1, 0, 0);
    idle(1); idle(1); idle(1);
    step(0, 0, 0, 1, 0, 1);
    chk("t5_frames", frame_cnt, 0);
    chk("t5_valid", out_valid, 0);
    chk("t5_data", out_data, 0);
    step(0, 0, 1, 1, 0, 0);
    idle(1);
    chk("t5_noout", out_valid, 0);
    step(0, 0, 0, 1, 1, 0);
    rd(2500, 500, 1);
    chk("t5_valid2", out_valid, 1);
    chk("t5_data2", out_data, 2000);
    chk("t5_frames2", frame_cnt, 1);
    idle(1);
`endif

    ph = 0; gap = 0;
    for (int k = 0; k < 2500; k++) begin
      c1 = 0; c2 = 0; cd = 0;
      if (gap > 0) gap--;
      else begin
        if (ph == 0) begin c1 = 1; ph = 1; end
        else if (ph == 1) begin c2 = 1; ph = 2; end
        else begin
          cd = 1; ph = 0;
          if ($urandom_range(3) == 0) begin c1 = 1; ph = 1; end
        end
        gap = $urandom_range(3);
      end
      if ($urandom_range(24) == 0) {c1, c2, cd} = 3'($urandom);
      if ((k / 200) % 3 == 2) rdy = ($urandom_range(9) == 0);
      else rdy = ($urandom_range(9) < 7);
      clr = ($urandom_range(29) == 0);
      rst = ($urandom_range(499) == 0);
      step(c1, c2, cd, rdy, clr, rst);
    end
    repeat (10) idle(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
